// File: rtl/serial_borrow_subtractor_if.sv
// Start/done handshake and operand/result bundle for serial_borrow_subtractor.
interface serial_borrow_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, with borrow-out and signed overflow.
// Define SUB_DUAL_BIT_EN to retire two bits per clock instead of one.
module serial_borrow_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    serial_borrow_subtractor_if.slave    sub_io
);
`ifdef SUB_DUAL_BIT_EN
    localparam int unsigned Step = 2;
`else
    localparam int unsigned Step = 1;
`endif
    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             borrow_q, borrow_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d, ovf_q, ovf_d;

    logic             d0, br0, br_last;
    logic [WIDTH-1:0] res_shift;

    assign d0  = a_q[0] ^ b_q[0] ^ borrow_q;
    assign br0 = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
    assign res_shift = res_q >> Step;

`ifdef SUB_DUAL_BIT_EN
    logic d1, br1;
    // Second bit of the pair takes its borrow straight from the first.
    assign d1  = a_q[1] ^ b_q[1] ^ br0;
    assign br1 = (~a_q[1] & b_q[1]) | (~(a_q[1] ^ b_q[1]) & br0);
    assign br_last = br1;
`else
    assign br_last = br0;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (sub_io.start) begin
                    a_d      = sub_io.a;
                    b_d      = sub_io.b;
                    a_msb_d  = sub_io.a[WIDTH-1];
                    b_msb_d  = sub_io.b[WIDTH-1];
                    borrow_d = sub_io.bin;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                a_d      = a_q >> Step;
                b_d      = b_q >> Step;
                borrow_d = br_last;
                cnt_d    = cnt_q + CntW'(Step);
                res_d    = res_shift;
`ifdef SUB_DUAL_BIT_EN
                res_d[WIDTH-1] = d1;
                res_d[WIDTH-2] = d0;
`else
                res_d[WIDTH-1] = d0;
`endif
                if (cnt_q == CntW'(WIDTH - Step)) begin
                    // Results are published only here so partial sums never leak out.
                    state_d = StDone;
                    diff_d  = res_d;
                    bout_d  = br_last;
                    ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ res_d[WIDTH-1]);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign sub_io.busy = (state_q == StRun);
    assign sub_io.done = (state_q == StDone);
    assign sub_io.diff = diff_q;
    assign sub_io.bout = bout_q;
    assign sub_io.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Directed self-checking bench for serial_borrow_subtractor (WIDTH=8).
module tb_serial_borrow_subtractor;
    localparam int unsigned W = 8;
`ifdef SUB_DUAL_BIT_EN
    localparam int BUSYN = W / 2;
`else
    localparam int BUSYN = W;
`endif
    localparam int LAT = BUSYN + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] last_diff = 8'h00;

    serial_borrow_subtractor_if #(.WIDTH(W)) sif ();

    serial_borrow_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sub_io(sif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one operation and checks latency, busy length, result and no partial updates.
    task automatic run_op(input vec_t v, input bit inject);
        int lat;
        int busy_n;
        bit seen;
        bit stable;
        @(negedge clk);
        sif.a = v.a; sif.b = v.b; sif.bin = v.bin; sif.start = 1'b1;
        lat = 0; busy_n = 0; seen = 0; stable = 1;
        while (!seen && lat < 40) begin
            @(negedge clk);
            sif.start = 1'b0;
            lat++;
            if (inject && lat == 3) begin
                sif.a = 8'h10; sif.b = 8'h10; sif.bin = 1'b0; sif.start = 1'b1;
            end
            if (sif.busy) busy_n++;
            if (sif.done) seen = 1;
            else if (sif.diff !== last_diff) stable = 0;
        end
        chk("latency", lat, LAT);
        chk("busy_len", busy_n, BUSYN);
        chk("no_partial", {31'd0, stable}, 32'd1);
        chk("diff", {24'd0, sif.diff}, {24'd0, v.diff});
        chk("bout", {31'd0, sif.bout}, {31'd0, v.bout});
        chk("ovf", {31'd0, sif.ovf}, {31'd0, v.ovf});
        @(negedge clk);
        chk("done_one_cycle", {30'd0, sif.done, sif.busy}, 32'd0);
        last_diff = v.diff;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[10];
        vec_t v;
        int   cyc;
        int   last;
        int   pulses;
        bit   extra;
        vecs[0] = '{8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
        vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};
        vecs[7] = '{8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[8] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[9] = '{8'h33, 8'h34, 1'b1, 8'hFE, 1'b1, 1'b0};

        sif.start = 1'b0; sif.a = '0; sif.b = '0; sif.bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state",
            {19'd0, sif.busy, sif.done, sif.diff, sif.bout, sif.ovf, 2'd0}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_op(vecs[i], 1'b0);

        // Start during busy must be ignored and must not cause a second done.
        v = '{8'h7F, 8'hFF, 1'b1, 8'h7F, 1'b1, 1'b0};
        run_op(v, 1'b1);
        extra = 0;
        repeat (W + 3) begin
            @(negedge clk);
            if (sif.done || sif.busy) extra = 1;
        end
        chk("ignored_start", {31'd0, extra}, 32'd0);
        chk("ignored_diff", {24'd0, sif.diff}, 32'h7F);

        // Reset during RUN clears everything at once and kills the pending done.
        @(negedge clk);
        sif.a = 8'h50; sif.b = 8'h20; sif.bin = 1'b0; sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_reset", {31'd0, sif.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset",
            {19'd0, sif.busy, sif.done, sif.diff, sif.bout, sif.ovf, 2'd0}, 32'd0);
        last_diff = 8'h00;
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (sif.done) extra = 1;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (sif.done || sif.busy) extra = 1;
        end
        chk("no_done_after_abort", {31'd0, extra}, 32'd0);
        run_op(vecs[8], 1'b0);

        // Back-to-back with start held: done every LAT cycles.
        @(negedge clk);
        sif.a = 8'h10; sif.b = 8'h01; sif.bin = 1'b0; sif.start = 1'b1;
        cyc = 0; last = 0; pulses = 0;
        while (pulses < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (sif.done) begin
                pulses++;
                chk("b2b_interval", cyc - last, LAT);
                chk("b2b_diff", {22'd0, sif.diff, sif.bout, sif.ovf}, {22'd0, 8'h0F, 2'b00});
                last = cyc;
                if (pulses == 3) sif.start = 1'b0;
            end
        end
        chk("b2b_pulses", pulses, 3);
        @(negedge clk);
        chk("b2b_stop", {30'd0, sif.busy, sif.done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
